rtc_countdown_timer: RTL

BCD countdown timer for the Real_Time_Clock design. It holds an HH:MM:SS value and decrements it by one second on each `tick` pulse until it reaches 00:00:00. `bcd_counter` counts up through its mod-N digits with an `ov` carry; this block is the opposite direction, counting down through the same digit moduli with a borrow chain. It sits beside the clock chain, shares the 1 Hz tick enable, and provides the alarm/timer function.

---
 rtl/rtc_countdown_timer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rtc_countdown_timer.sv
// rtc_countdown_timer
//
// BCD HH:MM:SS countdown timer. It decrements by one second on each 1 Hz
// `tick` while running, and stops at 00:00:00 with a one-cycle `done` pulse.
// Seconds and minutes count down through their mod-60 digits with a borrow
// chain. Hours count down as a BCD pair.
//
// Ports
//   clk        in   system clock, rising edge
//   rset       in   asynchronous active-low reset
//   tick       in   one-cycle 1 Hz enable
//   load       in   load preset (highest priority)
//   preset_hh  in   BCD hours preset
//   preset_mm  in   BCD minutes preset
//   preset_ss  in   BCD seconds preset
//   start      in   begin / resume counting
//   pause      in   suspend counting
//   hh, mm, ss out  current BCD value (registered)
//   busy       out  high while running (registered)
//   done       out  one-cycle pulse on reaching zero
//   err        out  sticky: last load was rejected
module rtc_countdown_timer #(
  parameter logic [7:0] HH_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] preset_hh,
  input  logic [7:0] preset_mm,
  input  logic [7:0] preset_ss,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e     state_q;
  logic [7:0] hh_q, mm_q, ss_q;
  logic       busy_q, done_q, err_q;

  // Decrement one BCD digit. If borrow_in is set, the digit either drops by
  // one or wraps to `wrap` and passes the borrow on. Returns {borrow_out, digit}.
  function automatic logic [4:0] dig_dec(input logic [3:0] d, input logic borrow_in,
                                         input logic [3:0] wrap);
    logic [4:0] r;
    if (!borrow_in) begin
      r = {1'b0, d};
    end else if (d == 4'd0) begin
      r = {1'b1, wrap};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  // Preset validation
  logic preset_ok;

  always_comb begin
    preset_ok = 1'b1;
    if (preset_hh[7:4] > 4'd9 || preset_hh[3:0] > 4'd9) preset_ok = 1'b0;
    if (preset_mm[7:4] > 4'd5 || preset_mm[3:0] > 4'd9) preset_ok = 1'b0;
    if (preset_ss[7:4] > 4'd5 || preset_ss[3:0] > 4'd9) preset_ok = 1'b0;
    // Both operands are valid BCD here, so a binary compare orders them correctly.
    if (preset_hh > HH_MAX) preset_ok = 1'b0;
  end

  // One-second decrement of the current value
  logic [4:0] ss_u_r, ss_t_r, mm_u_r, mm_t_r, hh_u_r, hh_t_r;
  logic [7:0] hh_dec, mm_dec, ss_dec;
  logic       dec_zero, cur_zero;

  always_comb begin
    ss_u_r = dig_dec(ss_q[3:0], 1'b1, 4'd9);
    ss_t_r = dig_dec(ss_q[7:4], ss_u_r[4], 4'd5);
    mm_u_r = dig_dec(mm_q[3:0], ss_t_r[4], 4'd9);
    mm_t_r = dig_dec(mm_q[7:4], mm_u_r[4], 4'd5);
    hh_u_r = dig_dec(hh_q[3:0], mm_t_r[4], 4'd9);
    // An hours-tens borrow is unreachable because RUN is never entered at zero.
    hh_t_r = dig_dec(hh_q[7:4], hh_u_r[4], 4'd0);

    ss_dec   = {ss_t_r[3:0], ss_u_r[3:0]};
    mm_dec   = {mm_t_r[3:0], mm_u_r[3:0]};
    hh_dec   = {hh_t_r[3:0], hh_u_r[3:0]};
    dec_zero = ({hh_dec, mm_dec, ss_dec} == 24'h0);
    cur_zero = ({hh_q, mm_q, ss_q} == 24'h0);
  end

  // Control FSM and registered datapath. Priority is load > pause > start.
  // A tick counts only when none of these acts on the same edge.
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_q <= StIdle;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        if (preset_ok) begin
          hh_q    <= preset_hh;
          mm_q    <= preset_mm;
          ss_q    <= preset_ss;
          state_q <= StIdle;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (pause) begin
        if (state_q == StRun) begin
          state_q <= StPaused;
          busy_q  <= 1'b0;
        end
      end else if (start && ((state_q == StIdle && !cur_zero) || state_q == StPaused)) begin
        state_q <= StRun;
        busy_q  <= 1'b1;
      end else if (state_q == StRun && tick) begin
        hh_q <= hh_dec;
        mm_q <= mm_dec;
        ss_q <= ss_dec;
        if (dec_zero) begin
          state_q <= StExpired;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign hh   = hh_q;
  assign mm   = mm_q;
  assign ss   = ss_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
